// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the Mem read arbiter slice.
//   state_t    - arbiter sequencer states (IDLE, ISSUE, WAIT, RESP)
//   SZ_*       - access size codes used on req_size*/mem_size
//   size_mask  - keeps the low 8<<size bits of a Mem read word
package mem_pkg;

  localparam int MEM_DATA_W = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  // Bytes above the access size must read back as zero.
  function automatic logic [MEM_DATA_W-1:0] size_mask(input logic [1:0] size);
    logic [MEM_DATA_W-1:0] mask;
    case (size)
      SZ_B:    mask = 64'h0000_0000_0000_00FF;
      SZ_H:    mask = 64'h0000_0000_0000_FFFF;
      SZ_W:    mask = 64'h0000_0000_FFFF_FFFF;
      default: mask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: combinational two-input round-robin pick.
//   req[1:0]    in   per-port request
//   last        in   port granted most recently
//   winner[1:0] out  one-hot winning port, zero when nobody requests
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] winner
);

  // A lone requester always wins; on a tie the port that did not win last time goes.
  always_comb begin
    winner = 2'b00;
    case (req)
      2'b01:   winner = 2'b01;
      2'b10:   winner = 2'b10;
      2'b11:   winner = last ? 2'b01 : 2'b10;
      default: winner = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_rd_arbiter.sv
// mem_rd_arbiter: two-port round-robin read arbiter and sequencer in front of Mem.
//   clk, reset                 single clock, synchronous active-high reset (shared with Mem)
//   req[1:0]                   per-port request, held until that port's gnt
//   req_addr0/1, req_size0/1   start byte address and size code per port
//   gnt[1:0]                   one-cycle one-hot pulse: request accepted
//   rvalid[1:0]                one-cycle one-hot pulse: rdata valid for that port
//   rdata                      size-masked little-endian result, held until next response
//   busy                       a transaction is in flight
//   mem_rd/mem_addr/mem_size   Mem read command
//   mem_data                   Mem registered read data
module mem_rd_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [1:0]        req_size0,
  input  logic [1:0]        req_size1,
  output logic [1:0]        gnt,
  output logic [1:0]        rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [1:0]        mem_size,
  input  logic [DATA_W-1:0] mem_data
);

  state_t              state_q, state_d;
  logic                lastPort_q, lastPort_d;
  logic                portId_q, portId_d;
  logic [1:0]          gnt_q, gnt_d;
  logic [1:0]          rvalid_q, rvalid_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                busy_q, busy_d;
  logic                memRd_q, memRd_d;
  logic [ADDR_W-1:0]   memAddr_q, memAddr_d;
  logic [1:0]          memSize_q, memSize_d;
  logic [1:0]          winner;
  logic [MEM_DATA_W-1:0] fullMask;

  rr_arb2 u_arb (
    .req    (req),
    .last   (lastPort_q),
    .winner (winner)
  );

  // memSize_q still holds the granted size while the read data is captured.
  assign fullMask = size_mask(memSize_q);

  // Next-state logic. Outputs are computed one state ahead so that every
  // output comes straight from a register: gnt/mem_rd are loaded on the way
  // into ISSUE, rvalid/rdata on the way into RESP. mem_addr/mem_size double
  // as the latched request.
  always_comb begin
    state_d    = state_q;
    lastPort_d = lastPort_q;
    portId_d   = portId_q;
    gnt_d      = 2'b00;
    rvalid_d   = 2'b00;
    rdata_d    = rdata_q;
    memRd_d    = 1'b0;
    memAddr_d  = memAddr_q;
    memSize_d  = memSize_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d    = ISSUE;
          portId_d   = winner[1];
          lastPort_d = winner[1];
          gnt_d      = winner;
          memRd_d    = 1'b1;
          memAddr_d  = winner[1] ? req_addr1 : req_addr0;
          memSize_d  = winner[1] ? req_size1 : req_size0;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        state_d  = RESP;
        rdata_d  = mem_data & fullMask[DATA_W-1:0];
        rvalid_d = portId_q ? 2'b10 : 2'b01;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset aborts any transaction and makes port 0
  // the winner of the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      lastPort_q <= 1'b1;
      portId_q   <= 1'b0;
      gnt_q      <= 2'b00;
      rvalid_q   <= 2'b00;
      rdata_q    <= '0;
      busy_q     <= 1'b0;
      memRd_q    <= 1'b0;
      memAddr_q  <= '0;
      memSize_q  <= 2'b00;
    end else begin
      state_q    <= state_d;
      lastPort_q <= lastPort_d;
      portId_q   <= portId_d;
      gnt_q      <= gnt_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      busy_q     <= busy_d;
      memRd_q    <= memRd_d;
      memAddr_q  <= memAddr_d;
      memSize_q  <= memSize_d;
    end
  end

  // Mem applies reset and read in the same edge, so a read issued while reset
  // is asserted would return cleared data; suppress the strobe in that cycle.
  assign mem_rd   = memRd_q & ~reset;
  assign gnt      = gnt_q;
  assign rvalid   = rvalid_q;
  assign rdata    = rdata_q;
  assign busy     = busy_q;
  assign mem_addr = memAddr_q;
  assign mem_size = memSize_q;

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// tb_mem_rd_arbiter: bench for mem_rd_arbiter with a behavioural Mem stub,
// a transaction-level expectation model and directed plus random stimulus.
module tb_mem_rd_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req;
  logic [3:0]  req_addr0, req_addr1;
  logic [1:0]  req_size0, req_size1;
  logic [1:0]  gnt, rvalid;
  logic [63:0] rdata;
  logic        busy, mem_rd;
  logic [3:0]  mem_addr;
  logic [1:0]  mem_size;
  logic [63:0] mem_data;

  logic [7:0]  memArr[16];
  logic [7:0]  memImage[16];
  logic        loadNow;

  int compared = 0;
  int mismatched = 0;

  mem_rd_arbiter #(.ADDR_W(4), .DATA_W(64)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_addr0 (req_addr0),
    .req_addr1 (req_addr1),
    .req_size0 (req_size0),
    .req_size1 (req_size1),
    .gnt       (gnt),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .busy      (busy),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_size  (mem_size),
    .mem_data  (mem_data)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Mem stub: 16 bytes, reset clears, then a read returns 8 bytes from addr
  // with modulo-16 wrap, registered. loadNow reloads contents from memImage.
  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        for (int i = 0; i < 16; i++) memArr[i] = 8'h00;
      end else if (loadNow) begin
        for (int i = 0; i < 16; i++) memArr[i] = memImage[i];
      end
      if (mem_rd) begin
        for (int b = 0; b < 8; b++) mem_data[8*b +: 8] <= memArr[4'(mem_addr + 4'(b))];
      end
    end
  end

  // Expectation model: each accepted request is a scheduled set of events
  // (gnt at +1, read at +1, rvalid at +3, busy +1..+3), kept in a ring of slots
  // indexed by absolute cycle number.
  logic [7:0]  refMem[16];
  logic [1:0]  expGnt[8];
  logic [1:0]  expRvalid[8];
  bit          expBusy[8];
  bit          expRd[8];
  logic [3:0]  expAddr[8];
  logic [1:0]  expSize[8];
  logic [63:0] expData[8];
  logic [63:0] expRdata;
  int          freeAt;
  int          cyc;
  bit          lastWin;
  bit          compareOn;

  function automatic logic [63:0] refRead(input logic [3:0] addr, input logic [1:0] size);
    logic [63:0] r = 64'h0;
    for (int b = 0; b < (1 << size); b++) r[8*b +: 8] = refMem[(int'(addr) + b) % 16];
    return r;
  endfunction

  task automatic clearSlot(input int s);
    expGnt[s] = 2'b00; expRvalid[s] = 2'b00; expBusy[s] = 1'b0; expRd[s] = 1'b0;
    expAddr[s] = 4'h0; expSize[s] = 2'b00; expData[s] = 64'h0;
  endtask

  initial begin
    int s;
    bit w;
    for (int i = 0; i < 8; i++) clearSlot(i);
    for (int i = 0; i < 16; i++) refMem[i] = 8'h00;
    expRdata = 64'h0; freeAt = 0; cyc = 0; lastWin = 1'b1; compareOn = 1'b0;
    forever begin
      @(negedge clk);
      s = cyc % 8;
      if (compareOn) begin
        if (expRvalid[s] != 2'b00) expRdata = expData[s];
        checkOutput("gnt", 64'(gnt), 64'(expGnt[s]));
        checkOutput("rvalid", 64'(rvalid), 64'(expRvalid[s]));
        checkOutput("busy", 64'(busy), 64'(expBusy[s]));
        checkOutput("mem_rd", 64'(mem_rd), 64'(expRd[s] & ~reset));
        checkOutput("rdata", rdata, expRdata);
        if (expRd[s] && !reset) begin
          checkOutput("mem_addr", 64'(mem_addr), 64'(expAddr[s]));
          checkOutput("mem_size", 64'(mem_size), 64'(expSize[s]));
        end
      end
      if (reset) begin
        for (int i = 0; i < 8; i++) clearSlot(i);
        for (int i = 0; i < 16; i++) refMem[i] = 8'h00;
        freeAt = cyc + 1; lastWin = 1'b1; expRdata = 64'h0; compareOn = 1'b1;
      end else begin
        if (loadNow) for (int i = 0; i < 16; i++) refMem[i] = memImage[i];
        if (expRd[s]) expData[(cyc + 2) % 8] = refRead(expAddr[s], expSize[s]);
        clearSlot(s);
        if (cyc >= freeAt && req != 2'b00) begin
          w = (req == 2'b11) ? !lastWin : req[1];
          lastWin = w;
          expGnt[(cyc + 1) % 8] = w ? 2'b10 : 2'b01;
          expRd[(cyc + 1) % 8] = 1'b1;
          expAddr[(cyc + 1) % 8] = w ? req_addr1 : req_addr0;
          expSize[(cyc + 1) % 8] = w ? req_size1 : req_size0;
          for (int k = 1; k <= 3; k++) expBusy[(cyc + k) % 8] = 1'b1;
          expRvalid[(cyc + 3) % 8] = w ? 2'b10 : 2'b01;
          freeAt = cyc + 4;
        end
      end
      cyc++;
    end
  end

  task automatic loadMem(input bit identity);
    for (int i = 0; i < 16; i++) memImage[i] = identity ? 8'(i) : 8'($urandom);
    loadNow = 1'b1;
    @(posedge clk); #1;
    loadNow = 1'b0;
  endtask

  task automatic doReset();
    req = 2'b00;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Raises the selected requests together after one idle cycle, drops each on
  // its gnt, and reports the cycle offsets of gnt/rvalid plus the data seen.
  task automatic applyStimulus(input logic [1:0] which,
                               input logic [3:0] a0, input logic [1:0] s0,
                               input logic [3:0] a1, input logic [1:0] s1,
                               output int g0, output int g1, output int v0, output int v1,
                               output logic [63:0] d0, output logic [63:0] d1);
    g0 = -1; g1 = -1; v0 = -1; v1 = -1; d0 = '0; d1 = '0;
    @(posedge clk); #1;
    req_addr0 = a0; req_size0 = s0; req_addr1 = a1; req_size1 = s1;
    req = which;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (gnt[0]) begin g0 = k; req[0] = 1'b0; end
      if (gnt[1]) begin g1 = k; req[1] = 1'b0; end
      if (rvalid[0]) begin v0 = k; d0 = rdata; end
      if (rvalid[1]) begin v1 = k; d1 = rdata; end
      if ((!which[0] || v0 >= 0) && (!which[1] || v1 >= 0)) break;
    end
    req = 2'b00;
  endtask

  initial begin
    int g0, g1, v0, v1;
    logic [63:0] d0, d1;
    reset = 1'b1; req = 2'b00; loadNow = 1'b0;
    req_addr0 = 4'h0; req_addr1 = 4'h0; req_size0 = 2'b00; req_size1 = 2'b00;
    for (int i = 0; i < 16; i++) memImage[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("reset gnt/rvalid/busy", {59'h0, gnt, rvalid, busy}, 64'h0);
    checkOutput("reset rdata", rdata, 64'h0);
    loadMem(1'b1);

    applyStimulus(2'b01, 4'd2, 2'b01, 4'd0, 2'b00, g0, g1, v0, v1, d0, d1);
    checkOutput("p0 half gnt cycle", 64'(g0), 64'd1);
    checkOutput("p0 half rvalid cycle", 64'(v0), 64'd3);
    checkOutput("p0 half data", d0, 64'h0302);

    applyStimulus(2'b10, 4'd0, 2'b00, 4'd14, 2'b10, g0, g1, v0, v1, d0, d1);
    checkOutput("p1 word wrap rvalid cycle", 64'(v1), 64'd3);
    checkOutput("p1 word wrap data", d1, 64'h0100_0F0E);

    doReset();
    loadMem(1'b1);
    applyStimulus(2'b11, 4'd9, 2'b11, 4'd0, 2'b00, g0, g1, v0, v1, d0, d1);
    checkOutput("tie p0 gnt cycle", 64'(g0), 64'd1);
    checkOutput("tie p0 data", d0, 64'h000F_0E0D_0C0B_0A09);
    checkOutput("tie p1 gnt cycle", 64'(g1), 64'd5);
    checkOutput("tie p1 rvalid cycle", 64'(v1), 64'd7);
    checkOutput("tie p1 data", d1, 64'h0);

    applyStimulus(2'b01, 4'd15, 2'b00, 4'd0, 2'b00, g0, g1, v0, v1, d0, d1);
    checkOutput("p0 byte data", d0, 64'h0F);

    applyStimulus(2'b11, 4'd9, 2'b11, 4'd0, 2'b00, g0, g1, v0, v1, d0, d1);
    checkOutput("alt tie p1 gnt cycle", 64'(g1), 64'd1);
    checkOutput("alt tie p0 gnt cycle", 64'(g0), 64'd5);

    // Reset while ISSUE is driving the read strobe.
    @(posedge clk); #1;
    req_addr0 = 4'd4; req_size0 = 2'b10; req = 2'b01;
    @(posedge clk); #1;
    checkOutput("issue gnt", 64'(gnt), 64'h1);
    req = 2'b00; reset = 1'b1;
    #1;
    checkOutput("mem_rd under reset", 64'(mem_rd), 64'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    checkOutput("after issue reset busy", 64'(busy), 64'h0);
    loadMem(1'b1);

    // Reset in the WAIT cycle aborts the transaction.
    req_addr0 = 4'd3; req_size0 = 2'b00; req = 2'b01;
    @(posedge clk); #1;
    req = 2'b00;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checkOutput("wait reset outputs", {52'h0, gnt, rvalid, busy, mem_rd, mem_addr, mem_size}, 64'h0);
    checkOutput("wait reset rdata", rdata, 64'h0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      checkOutput("no rvalid after abort", 64'(rvalid), 64'h0);
    end

    applyStimulus(2'b10, 4'd0, 2'b00, 4'd5, 2'b10, g0, g1, v0, v1, d0, d1);
    checkOutput("post reset p1 rvalid cycle", 64'(v1), 64'd3);
    checkOutput("post reset p1 data", d1, 64'h0);

    loadMem(1'b0);
    for (int n = 0; n < 2000; n++) begin
      @(posedge clk); #1;
      if (reset) begin
        reset = 1'b0;
        req = 2'b00;
        for (int i = 0; i < 16; i++) memImage[i] = 8'($urandom);
        loadNow = 1'b1;
      end else begin
        loadNow = 1'b0;
        if (req[0] && gnt[0]) req[0] = 1'b0;
        else if (!req[0] && $urandom_range(0, 3) == 0) begin
          req_addr0 = 4'($urandom); req_size0 = 2'($urandom); req[0] = 1'b1;
        end
        if (req[1] && gnt[1]) req[1] = 1'b0;
        else if (!req[1] && $urandom_range(0, 3) == 0) begin
          req_addr1 = 4'($urandom); req_size1 = 2'($urandom); req[1] = 1'b1;
        end
        if ($urandom_range(0, 199) == 0) reset = 1'b1;
      end
    end
    reset = 1'b0; req = 2'b00; loadNow = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mem_rd_arbiter.md
# mem_rd_arbiter

Two-port round-robin read arbiter and sequencer for the 16-byte `Mem` array. It accepts byte/half/word/double read requests from two independent requesters, such as a fetch port and a data port, and serialises them onto the single `Mem` read port. It drives `rd/addr/size`, captures `Mem`'s registered 64-bit `data` and returns a size-masked result to the granted requester. It sits between the requesters and `Mem`; `Mem` itself is unchanged.

## Interface
- `ADDR_W`, 4, byte address width; `Mem` depth is 2**ADDR_W.
- `DATA_W`, 64, read data width; max access is 8 bytes.
- `clk`  in  1  single clock; everything is on the rising edge.
- `reset`  in  1  reset is synchronous and active-high; it is also wired to `Mem.reset`.
- `req[1:0]`  in  2  per-port request; held high with stable `addr`/`size` until that port's `gnt`.
- `req_addr0`, `req_addr1`  in  ADDR_W  start byte address, per port.
- `req_size0`, `req_size1`  in  2  access size per port: 00=1B, 01=2B, 10=4B, 11=8B.
- `gnt[1:0]`  out  2  one-hot, one-cycle pulse: request accepted.
- `rvalid[1:0]`  out  2  one-hot, one-cycle pulse: `rdata` valid for that port.
- `rdata`  out  DATA_W  read result, little-endian; bytes above the access size are zero.
- `busy`  out  1  high while any transaction is in flight (state != IDLE).
- `mem_rd`  out  1  to `Mem.rd`.
- `mem_addr`  out  ADDR_W  to `Mem.addr`.
- `mem_size`  out  2  to `Mem.size`.
- `mem_data`  in  DATA_W  from `Mem.data`.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. All outputs are registered.
- IDLE: if any `req` is high, pick the winner, latch its addr/size and port id, then go to ISSUE. Otherwise stay in IDLE.
- ISSUE: `gnt[id]`=1, `mem_rd`=1, `mem_addr`/`mem_size` = latched values; next state is WAIT.
- WAIT: `mem_rd`=0. `Mem` updates `data` at the end of ISSUE, so `mem_data` is valid in this cycle. Capture it, apply the size mask, then go to RESP.
- RESP: `rvalid[id]`=1 and `rdata` = masked value; next state is IDLE.
- Arbitration: round-robin with a 1-bit `last` pointer.
  - One request: grant it.
  - Both requesting: grant the port != `last`.
  - `last` updates on each grant.
- Size mask keeps the low 8<<size bits: 0xFF, 0xFFFF, 0xFFFF_FFFF, all ones.
- Address wrap-around modulo 16 is performed by `Mem`; the arbiter passes `addr` unmodified.
- `req` of a port is ignored outside IDLE. A `req` still high in the cycle after `gnt` is a new request, so requesters must drop `req` on seeing `gnt`.
- Reset value of every output:
  - `gnt`=0, `rvalid`=0, `busy`=0.
  - `rdata`=0.
  - `mem_rd`=0, `mem_addr`=0, `mem_size`=0.
- Reset state: FSM=IDLE, `last`=1, so port 0 wins the first tie.
- Reset mid-transaction:
  - The transaction is aborted and no `rvalid` is produced.
  - `Mem` contents are cleared by the same reset, so post-reset reads return 0.
  - If `reset` and `mem_rd` coincide, `Mem` applies both in one edge (clear, then read), so the arbiter must ensure `mem_rd`=0 in any cycle where `reset`=1.

## Timing
- `req` sampled high in IDLE at cycle N gives: `gnt` at N+1, `rvalid`/`rdata` at N+3, back in IDLE at N+4.
- Fixed latency of 3 cycles from `req` to `rvalid`; throughput is one transaction per 4 cycles.
- `busy` is high in cycles N+1..N+3.
- Back-to-back: a request pending in cycle N+4 is granted at N+5.
- `rdata` holds its value until the next RESP.

## Structure
- Package `mem_pkg`:
  - state enum {IDLE, ISSUE, WAIT, RESP}.
  - size codes SZ_B=2'b00, SZ_H=2'b01, SZ_W=2'b10, SZ_D=2'b11.
  - function `size_mask(size)` returning the DATA_W mask.
- Sub-module `rr_arb2`: combinational 2-input round-robin pick (`req[1:0]`, `last`) -> one-hot winner. The `last` register stays in the parent.

## Test plan
`Mem` holds its initial contents mem[i]=i.
- Port 0 only, addr=2, size=01 -> `gnt`=01 at N+1, `rvalid`=01 at N+3, `rdata`=0x0302.
- Port 1 only, addr=14, size=10 (wrap) -> `rvalid`=10 at N+3, `rdata`=0x0100_0F0E.
- Port 0 addr=9 size=11 and port 1 addr=0 size=00, both requested in the same cycle, out of reset.
  - Port 0 goes first: `rdata`=0x000F_0E0D_0C0B_0A09.
  - Port 1 is granted at N+5: `rdata`=0x00.
  - Both requesting again: the winner alternates.
- Port 0 addr=15 size=00 -> `rdata`=0x0F with upper 56 bits zero.
- Assert `reset` in the WAIT cycle:
  - No `rvalid`; all outputs are 0 the next cycle.
  - A subsequent port 1 read of addr 5, size 10 returns 0x0000_0000.
